// File: rtl/ascon_aead_ctrl.sv
// ascon_aead_ctrl
//
// ASCON-128 AEAD sequencer. Owns the 320-bit state {x0,x1,x2,x3,x4}
// (x0 in the MSBs). An external round engine does the permutation
// through a start/done handshake. Handles 0..MAX_BLOCKS associated-data
// blocks and 0..MAX_BLOCKS data blocks per message. The caller pads all
// blocks to 64 bits before sending them.
//
// Optional feature: define ASCON_DECRYPT_EN to build the decrypt path and
// the tag check. Without it, decrypt_i and tag_i are ignored, auth_ok_o is
// 0, and every message is encrypted.
//
// Ports
//   clock_i, reset_i          clock (rising edge), async active-high reset
//   start_i, decrypt_i        message request; mode sampled with start_i
//   ad_blocks_i, data_blocks_i block counts (saturate at MAX_BLOCKS)
//   key_i, nonce_i            K and N, sampled with start_i
//   data_i, data_valid_i      AD blocks, then plaintext/ciphertext blocks
//   data_ready_o              high in AD_WAIT / DATA_WAIT
//   tag_i                     expected tag, sampled in TAG
//   perm_start_o              one-cycle permutation request
//   perm_rounds_o             12 or 6 while a permutation is outstanding
//   perm_state_o              state presented to the round engine
//   perm_state_i, perm_done_i permuted state and its completion pulse
//   cipher_o, cipher_valid_o  output block and its one-cycle strobe
//   tag_o, auth_ok_o          final tag and tag-match flag, held
//   end_o                     one-cycle end-of-message pulse
//   busy_o                    message in progress
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for start_i
// INIT_P    | p12 over {IV,K,N}
// INIT_K    | x3,x4 ^= K
// AD_WAIT   | waiting for an AD block; x0 ^= A on accept
// AD_P      | p6 after an AD block
// DSEP      | domain separation x4 ^= 1
// DATA_WAIT | waiting for a data block; emits one output block
// DATA_P    | p6 between data blocks
// FIN_P     | p12 finalisation (x1,x2 already keyed)
// TAG       | tag = {x3,x4} ^ K, pulse end_o
module ascon_aead_ctrl #(
    parameter int MAX_BLOCKS = 16,
    parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [CNT_W-1:0] ad_blocks_i,
    input  logic [CNT_W-1:0] data_blocks_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     nonce_i,
    input  logic [63:0]      data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [127:0]     tag_i,
    output logic             perm_start_o,
    output logic [3:0]       perm_rounds_o,
    output logic [319:0]     perm_state_o,
    input  logic [319:0]     perm_state_i,
    input  logic             perm_done_i,
    output logic [63:0]      cipher_o,
    output logic             cipher_valid_o,
    output logic [127:0]     tag_o,
    output logic             auth_ok_o,
    output logic             end_o,
    output logic             busy_o
);

    localparam logic [63:0]      ASCON_IV = 64'h80400c0600000000;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BLOCKS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_P,
        S_INIT_K,
        S_AD_WAIT,
        S_AD_P,
        S_DSEP,
        S_DATA_WAIT,
        S_DATA_P,
        S_FIN_P,
        S_TAG
    } state_t;

    state_t             state_q, state_d;
    logic [319:0]       s_q, s_d;
    logic [127:0]       key_q, key_d;
    logic [CNT_W-1:0]   ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0]   dat_cnt_q, dat_cnt_d;
    logic               dec_q, dec_d;
    logic               perm_start_q, perm_start_d;
    logic [63:0]        cipher_q, cipher_d;
    logic               cipher_valid_q, cipher_valid_d;
    logic [127:0]       tag_q, tag_d;
    logic               auth_q, auth_d;
    logic               end_q, end_d;
    logic [63:0]        x0;
    logic               dec_sel;
    logic [127:0]       tag_cmp;

    assign x0 = s_q[319:256];

`ifdef ASCON_DECRYPT_EN
    assign dec_sel = decrypt_i;
    assign tag_cmp = tag_i;
`else
    assign dec_sel = 1'b0;
    assign tag_cmp = '0;
    wire   unused_dec_inputs = &{1'b0, decrypt_i, tag_i};
`endif

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            s_q            <= '0;
            key_q          <= '0;
            ad_cnt_q       <= '0;
            dat_cnt_q      <= '0;
            dec_q          <= 1'b0;
            perm_start_q   <= 1'b0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
            tag_q          <= '0;
            auth_q         <= 1'b0;
            end_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            key_q          <= key_d;
            ad_cnt_q       <= ad_cnt_d;
            dat_cnt_q      <= dat_cnt_d;
            dec_q          <= dec_d;
            perm_start_q   <= perm_start_d;
            cipher_q       <= cipher_d;
            cipher_valid_q <= cipher_valid_d;
            tag_q          <= tag_d;
            auth_q         <= auth_d;
            end_q          <= end_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        key_d          = key_q;
        ad_cnt_d       = ad_cnt_q;
        dat_cnt_d      = dat_cnt_q;
        dec_d          = dec_q;
        perm_start_d   = 1'b0;
        cipher_d       = cipher_q;
        cipher_valid_d = 1'b0;
        tag_d          = tag_q;
        auth_d         = auth_q;
        end_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    s_d          = {ASCON_IV, key_i, nonce_i};
                    key_d        = key_i;
                    dec_d        = dec_sel;
                    ad_cnt_d     = sat_cnt(ad_blocks_i);
                    dat_cnt_d    = sat_cnt(data_blocks_i);
                    tag_d        = '0;
                    auth_d       = 1'b0;
                    perm_start_d = 1'b1;
                    state_d      = S_INIT_P;
                end
            end
            // A done in the same cycle as our own start pulse cannot be the
            // answer to it, so it is ignored.
            S_INIT_P, S_AD_P, S_DATA_P, S_FIN_P: begin
                if (perm_done_i && !perm_start_q) begin
                    s_d = perm_state_i;
                    case (state_q)
                        S_INIT_P: state_d = S_INIT_K;
                        S_AD_P:   state_d = (ad_cnt_q != '0) ? S_AD_WAIT : S_DSEP;
                        S_DATA_P: state_d = S_DATA_WAIT;
                        default:  state_d = S_TAG;
                    endcase
                end
            end
            S_INIT_K: begin
                s_d[127:0] = s_q[127:0] ^ key_q;
                state_d    = (ad_cnt_q != '0) ? S_AD_WAIT : S_DSEP;
            end
            S_AD_WAIT: begin
                if (data_valid_i) begin
                    s_d[319:256] = x0 ^ data_i;
                    ad_cnt_d     = ad_cnt_q - ONE_CNT;
                    perm_start_d = 1'b1;
                    state_d      = S_AD_P;
                end
            end
            S_DSEP: begin
                s_d[0] = ~s_q[0];
                if (dat_cnt_q != '0) begin
                    state_d = S_DATA_WAIT;
                end else begin
                    s_d[255:128] = s_q[255:128] ^ key_q;
                    perm_start_d = 1'b1;
                    state_d      = S_FIN_P;
                end
            end
            S_DATA_WAIT: begin
                if (data_valid_i) begin
                    // Output is x0 ^ block in both modes; decrypt then
                    // replaces x0 with the ciphertext itself.
                    cipher_d       = x0 ^ data_i;
                    cipher_valid_d = 1'b1;
                    s_d[319:256]   = dec_q ? data_i : (x0 ^ data_i);
                    dat_cnt_d      = dat_cnt_q - ONE_CNT;
                    perm_start_d   = 1'b1;
                    if (dat_cnt_q == ONE_CNT) begin
                        s_d[255:128] = s_q[255:128] ^ key_q;
                        state_d      = S_FIN_P;
                    end else begin
                        state_d = S_DATA_P;
                    end
                end
            end
            S_TAG: begin
                tag_d   = s_q[127:0] ^ key_q;
                auth_d  = dec_q && (tag_d == tag_cmp);
                end_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        perm_rounds_o = 4'd0;
        case (state_q)
            S_INIT_P, S_FIN_P: perm_rounds_o = 4'd12;
            S_AD_P, S_DATA_P:  perm_rounds_o = 4'd6;
            default:           perm_rounds_o = 4'd0;
        endcase
    end

    assign data_ready_o   = (state_q == S_AD_WAIT) || (state_q == S_DATA_WAIT);
    assign busy_o         = (state_q != S_IDLE);
    assign perm_start_o   = perm_start_q;
    assign perm_state_o   = s_q;
    assign cipher_o       = cipher_q;
    assign cipher_valid_o = cipher_valid_q;
    assign tag_o          = tag_q;
    assign auth_ok_o      = auth_q;
    assign end_o          = end_q;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Testbench for ascon_aead_ctrl: a round engine with random latency, a
// reference AEAD model over block queues, and randomized messages.
module tb_ascon_aead_ctrl;

    localparam int MAX_BLOCKS = 16;
    localparam int CNT_W      = $clog2(MAX_BLOCKS + 1);
    localparam logic [63:0] IV = 64'h80400c0600000000;
`ifdef ASCON_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic             start_i;
    logic             decrypt_i;
    logic [CNT_W-1:0] ad_blocks_i;
    logic [CNT_W-1:0] data_blocks_i;
    logic [127:0]     key_i;
    logic [127:0]     nonce_i;
    logic [63:0]      data_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic [127:0]     tag_i;
    logic             perm_start_o;
    logic [3:0]       perm_rounds_o;
    logic [319:0]     perm_state_o;
    logic [319:0]     perm_state_i;
    logic             perm_done_i;
    logic [63:0]      cipher_o;
    logic             cipher_valid_o;
    logic [127:0]     tag_o;
    logic             auth_ok_o;
    logic             end_o;
    logic             busy_o;

    ascon_aead_ctrl #(.MAX_BLOCKS(MAX_BLOCKS)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
        .decrypt_i(decrypt_i), .ad_blocks_i(ad_blocks_i),
        .data_blocks_i(data_blocks_i), .key_i(key_i), .nonce_i(nonce_i),
        .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .tag_i(tag_i),
        .perm_start_o(perm_start_o), .perm_rounds_o(perm_rounds_o),
        .perm_state_o(perm_state_o), .perm_state_i(perm_state_i),
        .perm_done_i(perm_done_i), .cipher_o(cipher_o),
        .cipher_valid_o(cipher_valid_o), .tag_o(tag_o),
        .auth_ok_o(auth_ok_o), .end_o(end_o), .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ASCON permutation (final nr rounds of p12).
    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_p(input logic [319:0] s, input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int r = 12 - nr; r < 12; r++) begin
            x2 ^= 64'((15 - r) * 16 + r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1)  ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    // Round engine: answers each perm_start_o after lat_fix cycles
    // (random 1..4 when lat_fix is 0), recording the round count asked for.
    int           lat_fix = 0;
    bit           eng_pending = 1'b0;
    int           eng_cnt;
    logic [319:0] eng_res;
    int           rounds_q[$];

    initial begin
        perm_done_i  = 1'b0;
        perm_state_i = '0;
        forever begin
            @(negedge clock_i);
            perm_done_i = 1'b0;
            if (eng_pending) begin
                if (eng_cnt <= 1) begin
                    perm_state_i = eng_res;
                    perm_done_i  = 1'b1;
                    eng_pending  = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end else if (perm_start_o) begin
                rounds_q.push_back(int'(perm_rounds_o));
                eng_res     = ascon_p(perm_state_o, int'(perm_rounds_o));
                eng_cnt     = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
                eng_pending = 1'b1;
            end
        end
    end

    logic [63:0] ad_blk[$];
    logic [63:0] dat_blk[$];
    logic [63:0] exp_out[$];
    logic [63:0] out_got[$];
    logic [127:0] tag_got;
    logic         auth_got;

    // Reference ASCON-128 AEAD over the block queues.
    task automatic model(input logic [127:0] k, input logic [127:0] n, input int n_ad,
                         input int n_dat, input bit dec, output logic [127:0] tag_out);
        logic [319:0] s;
        logic [63:0]  c;
        exp_out.delete();
        s = ascon_p({IV, k, n}, 12);
        s[127:0] ^= k;
        for (int i = 0; i < n_ad; i++) begin
            s[319:256] ^= ad_blk[i];
            s = ascon_p(s, 6);
        end
        s[0] ^= 1'b1;
        for (int i = 0; i < n_dat; i++) begin
            if (dec) begin
                c = s[319:256] ^ dat_blk[i];
                s[319:256] = dat_blk[i];
            end else begin
                s[319:256] ^= dat_blk[i];
                c = s[319:256];
            end
            exp_out.push_back(c);
            if (i < n_dat - 1) s = ascon_p(s, 6);
        end
        s[255:128] ^= k;
        s = ascon_p(s, 12);
        tag_out = s[127:0] ^ k;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_blocks(input int na, input int nd);
        ad_blk.delete();
        dat_blk.delete();
        for (int i = 0; i < na; i++) ad_blk.push_back(rnd64());
        for (int i = 0; i < nd; i++) dat_blk.push_back(rnd64());
    endtask

    task automatic check_outputs_zero(input string name);
        check_val({name, "_ctl"}, {data_ready_o, perm_start_o, perm_rounds_o, cipher_valid_o,
                                   auth_ok_o, end_o, busy_o}, 0);
        check_val({name, "_cipher"}, cipher_o, 0);
        check_val({name, "_tag"}, tag_o, 0);
        check_val({name, "_state"}, |perm_state_o, 0);
    endtask

    // Runs one message, feeding eff_ad AD blocks then eff_dat data blocks,
    // and checks outputs, tag, auth, round sequence and handshake behaviour.
    task automatic run_msg(input string name, input logic [127:0] k, input logic [127:0] n,
                           input int ad_n, input int dat_n, input bit dec,
                           input logic [127:0] tag_in, input int gap, input bit poke);
        int eff_ad, eff_dat, total, idx, gap_cnt, extra, ends;
        bit done;
        logic [127:0] tag_exp;
        logic [63:0] blks[$];
        int exp_rounds[$];
        eff_ad  = (ad_n > MAX_BLOCKS) ? MAX_BLOCKS : ad_n;
        eff_dat = (dat_n > MAX_BLOCKS) ? MAX_BLOCKS : dat_n;
        model(k, n, eff_ad, eff_dat, dec && DEC_EN, tag_exp);
        exp_rounds.push_back(12);
        for (int i = 0; i < eff_ad; i++) exp_rounds.push_back(6);
        for (int i = 1; i < eff_dat; i++) exp_rounds.push_back(6);
        exp_rounds.push_back(12);
        for (int i = 0; i < eff_ad; i++) blks.push_back(ad_blk[i]);
        for (int i = 0; i < eff_dat; i++) blks.push_back(dat_blk[i]);
        total = eff_ad + eff_dat;
        rounds_q.delete();
        out_got.delete();
        idx = 0; gap_cnt = 0; extra = 0; done = 1'b0; ends = 0;

        @(negedge clock_i);
        key_i = k; nonce_i = n; decrypt_i = dec; tag_i = tag_in;
        ad_blocks_i = CNT_W'(ad_n); data_blocks_i = CNT_W'(dat_n);
        start_i = 1'b1; data_valid_i = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clock_i);
            start_i = poke && (cyc == 5);
            key_i   = (poke && cyc == 5) ? ~k : k;
            if (cipher_valid_o) out_got.push_back(cipher_o);
            if (end_o) begin
                done = 1'b1; ends = 1; tag_got = tag_o; auth_got = auth_ok_o;
            end
            if (idx >= total && data_ready_o) extra++;
            if (idx < total && gap_cnt == 0) begin
                data_valid_i = 1'b1;
                data_i = blks[idx];
                if (data_ready_o) begin
                    idx++;
                    gap_cnt = gap;
                end
            end else begin
                data_valid_i = 1'b0;
                data_i = rnd64();
                if (gap_cnt > 0) gap_cnt--;
            end
        end
        start_i = 1'b0;
        data_valid_i = 1'b0;
        check_val({name, "_done"}, done, 1);
        check_val({name, "_accepted"}, idx, total);
        check_val({name, "_extra_ready"}, extra, 0);
        check_val({name, "_nout"}, out_got.size(), eff_dat);
        for (int i = 0; i < eff_dat && i < out_got.size(); i++)
            check_val($sformatf("%s_out%0d", name, i), out_got[i], exp_out[i]);
        check_val({name, "_tag"}, tag_got, tag_exp);
        check_val({name, "_auth"}, auth_got, DEC_EN && dec && (tag_exp == tag_in));
        check_val({name, "_nperm"}, rounds_q.size(), exp_rounds.size());
        for (int i = 0; i < exp_rounds.size() && i < rounds_q.size(); i++)
            check_val($sformatf("%s_rounds%0d", name, i), rounds_q[i], exp_rounds[i]);
        repeat (3) begin
            @(negedge clock_i);
            if (end_o) ends++;
        end
        check_val({name, "_end_pulses"}, ends, 1);
        check_val({name, "_idle"}, busy_o, 0);
        check_val({name, "_tag_hold"}, tag_o, tag_exp);
    endtask

    logic [127:0] k0, n0, enc_tag;
    logic [63:0]  enc_ct[$];
    logic [63:0]  enc_pt[$];
    int           na, nd;
    bit           waited;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; start_i = 1'b0; decrypt_i = 1'b0;
        ad_blocks_i = '0; data_blocks_i = '0; key_i = '0; nonce_i = '0;
        data_i = '0; data_valid_i = 1'b0; tag_i = '0;
        repeat (3) @(negedge clock_i);
        check_outputs_zero("reset");
        reset_i = 1'b0;
        @(negedge clock_i);
        check_outputs_zero("post_reset");

        // Known-answer style message: ad=0, one padded data block.
        k0 = 128'h000102030405060708090a0b0c0d0e0f;
        n0 = 128'h00112233445566778899aabbccddeeff;
        ad_blk.delete(); dat_blk.delete();
        dat_blk.push_back(64'h3230323380000000);
        run_msg("kat", k0, n0, 0, 1, 1'b0, '0, 0, 1'b0);

        // ad=2, data=3, 3-cycle valid gaps; start_i poked while busy.
        k0 = rnd128(); n0 = rnd128();
        fill_blocks(2, 3);
        run_msg("enc23", k0, n0, 2, 3, 1'b0, '0, 3, 1'b1);
        enc_tag = tag_got;
        enc_ct  = out_got;
        enc_pt  = dat_blk;

        // Decrypt the previous ciphertext, correct then corrupted tag.
        dat_blk = enc_ct;
        run_msg("dec_ok", k0, n0, 2, 3, 1'b1, enc_tag, 1, 1'b0);
`ifdef ASCON_DECRYPT_EN
        for (int i = 0; i < 3; i++)
            check_val($sformatf("dec_ok_pt%0d", i), out_got[i], enc_pt[i]);
        check_val("dec_ok_auth_one", auth_got, 1);
        check_val("dec_ok_tag_match", tag_got, enc_tag);
`else
        check_val("enc_only_auth_zero", auth_got, 0);
`endif
        run_msg("dec_bad", k0, n0, 2, 3, 1'b1, enc_tag ^ 128'h1, 0, 1'b0);
        check_val("dec_bad_auth_zero", auth_got, 0);

        // Count boundaries: saturated AD count, then zero data blocks.
        fill_blocks(20, 2);
        run_msg("ad_sat", rnd128(), rnd128(), 20, 2, 1'b0, '0, 0, 1'b0);
        fill_blocks(3, 0);
        run_msg("no_data", rnd128(), rnd128(), 3, 0, 1'b0, '0, 1, 1'b0);
        fill_blocks(0, 0);
        run_msg("empty", rnd128(), rnd128(), 0, 0, 1'b0, '0, 0, 1'b0);

        // Reset while the AD permutation is outstanding.
        lat_fix = 6;
        fill_blocks(2, 1);
        @(negedge clock_i);
        key_i = rnd128(); nonce_i = rnd128(); decrypt_i = 1'b0;
        ad_blocks_i = CNT_W'(2); data_blocks_i = CNT_W'(1); start_i = 1'b1;
        waited = 1'b0;
        for (int cyc = 0; cyc < 200 && !waited; cyc++) begin
            @(negedge clock_i);
            start_i = 1'b0;
            data_valid_i = 1'b1;
            data_i = ad_blk[0];
            if (perm_rounds_o == 4'd6 && eng_pending) waited = 1'b1;
        end
        data_valid_i = 1'b0;
        check_val("abort_reached_ad_p", waited, 1);
        reset_i = 1'b1;
        @(negedge clock_i);
        check_outputs_zero("abort_reset");
        reset_i = 1'b0;
        waited = 1'b0;
        for (int cyc = 0; cyc < 50 && !waited; cyc++) begin
            @(negedge clock_i);
            if (!eng_pending) waited = 1'b1;
        end
        check_val("abort_late_done_sent", waited, 1);
        repeat (2) @(negedge clock_i);
        check_val("abort_late_done_busy", busy_o, 0);
        check_val("abort_late_done_state", |perm_state_o, 0);
        lat_fix = 0;
        fill_blocks(1, 2);
        run_msg("after_abort", rnd128(), rnd128(), 1, 2, 1'b0, '0, 0, 1'b0);

        // Random messages, each followed by a decrypt of its ciphertext.
        for (int m = 0; m < 4; m++) begin
            na = int'($urandom_range(0, MAX_BLOCKS));
            nd = int'($urandom_range(0, MAX_BLOCKS));
            k0 = rnd128(); n0 = rnd128();
            fill_blocks(na, nd);
            run_msg($sformatf("rnd%0d_enc", m), k0, n0, na, nd, 1'b0, '0,
                    int'($urandom_range(0, 2)), 1'b0);
            dat_blk = out_got;
            run_msg($sformatf("rnd%0d_dec", m), k0, n0, na, nd, 1'b1, tag_got,
                    int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_aead_ctrl.md
# ascon_aead_ctrl

Parametrised ASCON-128 AEAD sequencer. Owns the 320-bit state and drives an external permutation round engine through a start/done handshake. Supports variable counts of associated-data (AD) and data blocks per message, plus encrypt and optional decrypt-with-tag-check. Sits between the system data interface and the permutation core, generalising the fixed single-block encrypt toplevel.

## Interface
Parameters:
- MAX_BLOCKS, 16, largest AD or data block count per message
- CNT_W, $clog2(MAX_BLOCKS+1), width of block-count inputs/counters

Ports:
- clock_i  in  1  clock; all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle request; samples key/nonce/counts/mode
- decrypt_i  in  1  1 = decrypt, 0 = encrypt; sampled with start_i
- ad_blocks_i  in  CNT_W  AD block count, 0..MAX_BLOCKS
- data_blocks_i  in  CNT_W  data block count, 0..MAX_BLOCKS
- key_i  in  128  key K
- nonce_i  in  128  nonce N
- data_i  in  64  AD block, then plaintext/ciphertext block; caller pre-pads
- data_valid_i  in  1  data_i valid
- data_ready_o  out  1  block accepted when data_valid_i & data_ready_o
- tag_i  in  128  expected tag (decrypt), sampled in TAG state
- perm_start_o  out  1  one-cycle pulse requesting permutation
- perm_rounds_o  out  4  12 or 6, held with perm_state_o
- perm_state_o  out  320  {x0..x4}, stable from perm_start_o until perm_done_i
- perm_state_i  in  320  permuted state, valid with perm_done_i
- perm_done_i  in  1  one-cycle completion pulse
- cipher_o  out  64  output block (C when encrypt, P when decrypt)
- cipher_valid_o  out  1  one-cycle pulse with cipher_o
- tag_o  out  128  computed tag, held until next accepted start
- auth_ok_o  out  1  decrypt: tag_o == tag_i; held with tag_o
- end_o  out  1  one-cycle pulse, message complete
- busy_o  out  1  high from accepted start to end_o

## Operation
- States: IDLE, INIT_P, INIT_K, AD_WAIT, AD_P, DSEP, DATA_WAIT, DATA_P, FIN_P, TAG.
- IDLE: start_i loads S = {64'h80400c0600000000, K, N}, latches counts (values > MAX_BLOCKS saturate to MAX_BLOCKS) → INIT_P (p12).
- INIT_K: x3,x4 ^= K. Then → AD_WAIT if ad count > 0, else → DSEP.
- AD_WAIT: accept block, x0 ^= A → AD_P (p6). Decrement count; → AD_WAIT or DSEP.
- DSEP: x4 ^= 1. Then → DATA_WAIT if data count > 0, else → FIN_P.
- DATA_WAIT, encrypt: x0 ^= P; cipher_o = new x0.
- DATA_WAIT, decrypt: cipher_o = x0 ^ C; x0 = C.
- After DATA_WAIT: not-last block → DATA_P (p6) → DATA_WAIT. Last block → x1,x2 ^= K → FIN_P (p12).
- Decrypt handles full 64-bit final blocks only; no partial-block handling.
- TAG: tag_o = {x3,x4} ^ K; auth_ok_o = (tag_o == tag_i) when decrypting, else 0. Pulse end_o → IDLE.
- FIN_P with zero data blocks: x1,x2 ^= K applied on DSEP exit.
- start_i while busy_o: ignored.
- perm_done_i outside *_P states: ignored.
- data_valid_i while data_ready_o low: ignored.
- reset_i asserted mid-message: immediate return to IDLE; in-flight permutation result discarded.

## Timing
- Reset values: all outputs 0; state IDLE.
- perm_start_o pulses the cycle after entering a *_P state.
- perm_state_i is captured on the perm_done_i cycle; the next state follows on the next edge.
- data_ready_o is combinational from state: high only in AD_WAIT/DATA_WAIT.
- cipher_valid_o is registered: asserted the cycle after block acceptance.
- end_o, tag_o and auth_ok_o update in the same cycle, one cycle after leaving FIN_P.
- Minimum message latency (0-cycle data stall, perm latency L): 4 + (1+L)·(2 + ad + data − 1) + ad/data acceptance cycles.

## Configuration
- ASCON_DECRYPT_EN defined: decrypt path, tag_i comparison and auth_ok_o are implemented.
- ASCON_DECRYPT_EN undefined: decrypt_i and tag_i are ignored, auth_ok_o is tied 0, and every message is encrypted.

## Test plan
- Encrypt, K=000102…0f, N=0011…ff, ad=0, data=1, P=3230323380000000:
  - perm_rounds_o sequence 12, 12.
  - cipher_o and tag_o match the ASCON-128 C reference.
  - end_o pulses once.
- Encrypt, ad=2, data=3, with data_valid_i gaps of 3 cycles:
  - rounds sequence 12, 6, 6, 6, 6, 12.
  - exactly 3 cipher_valid_o pulses.
  - outputs match the model.
- Decrypt of the previous ciphertext with the correct tag_i:
  - plaintext returned.
  - auth_ok_o=1.
- Decrypt with tag_i bit 0 flipped: auth_ok_o=0.
- Boundary counts:
  - ad_blocks_i=20 with MAX_BLOCKS=16: exactly 16 AD blocks accepted.
  - data_blocks_i=0: no data_ready_o in data phase, tag still produced.
- reset_i asserted during AD_P:
  - all outputs 0 next cycle.
  - late perm_done_i ignored.
  - following start_i completes normally.
